// File: rtl/reg_file_ctx_if.sv
// Bus bundle for reg_file_ctx: write/read ports, load scoreboard and the
// context-save stream. The master side drives the register file.
interface reg_file_ctx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
);
    localparam int AW = $clog2(NUM_REGS);

    logic                  ld_reg;
    logic [AW-1:0]         dr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [AW-1:0]         sr1;
    logic [AW-1:0]         sr2;
    logic [DATA_WIDTH-1:0] sr1_out;
    logic [DATA_WIDTH-1:0] sr2_out;
    logic                  busy_set;
    logic [AW-1:0]         busy_dr;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  sr1_busy;
    logic                  sr2_busy;
    logic                  save_req;
    logic                  save_valid;
    logic                  save_ready;
    logic [AW-1:0]         save_idx;
    logic [DATA_WIDTH-1:0] save_data;
    logic                  save_done;
    logic                  ctx_busy;

    modport master (
        output ld_reg, dr, data_in, sr1, sr2, busy_set, busy_dr, save_req, save_ready,
        input  sr1_out, sr2_out, busy_vec, sr1_busy, sr2_busy,
               save_valid, save_idx, save_data, save_done, ctx_busy
    );

    modport slave (
        input  ld_reg, dr, data_in, sr1, sr2, busy_set, busy_dr, save_req, save_ready,
        output sr1_out, sr2_out, busy_vec, sr1_busy, sr2_busy,
               save_valid, save_idx, save_data, save_done, ctx_busy
    );
endinterface

// File: rtl/reg_file_ctx.sv
// Register file with write-through read bypass, a load-pending scoreboard and
// a context-save engine that streams every register out over valid/ready.
//
// state  | meaning
// IDLE   | waiting for save_req
// SAVE   | presenting register ptr on the save stream until accepted
// DONE   | one-cycle save_done pulse, then back to IDLE
module reg_file_ctx #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input logic          clk,
    input logic          reset,
    reg_file_ctx_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_DONE
    } state_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    state_e                state_q;
    state_e                state_d;
    logic [AW-1:0]         ptr_q;
    logic [AW-1:0]         ptr_d;
    logic                  save_valid;
    logic                  save_done;
    logic                  ctx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            if (bus.ld_reg) begin
                regs_q[bus.dr] <= bus.data_in;
            end
            busy_q  <= busy_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The set is applied after the clear so a same-index collision leaves the bit pending.
    always_comb begin
        busy_d = busy_q;
        if (bus.ld_reg) begin
            busy_d[bus.dr] = 1'b0;
        end
        if (bus.busy_set) begin
            busy_d[bus.busy_dr] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        save_valid = 1'b0;
        save_done  = 1'b0;
        ctx_busy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.save_req) begin
                    state_d = S_SAVE;
                    ptr_d   = '0;
                end
            end
            S_SAVE: begin
                save_valid = 1'b1;
                ctx_busy   = 1'b1;
                if (bus.save_ready) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = S_DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                save_done = 1'b1;
                ctx_busy  = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Same-cycle writeback is forwarded to every read path, including the save stream.
    assign bus.sr1_out   = (bus.ld_reg && bus.dr == bus.sr1) ? bus.data_in : regs_q[bus.sr1];
    assign bus.sr2_out   = (bus.ld_reg && bus.dr == bus.sr2) ? bus.data_in : regs_q[bus.sr2];
    assign bus.save_data = (bus.ld_reg && bus.dr == ptr_q)   ? bus.data_in : regs_q[ptr_q];

    assign bus.sr1_busy   = busy_q[bus.sr1] && !(bus.ld_reg && bus.dr == bus.sr1);
    assign bus.sr2_busy   = busy_q[bus.sr2] && !(bus.ld_reg && bus.dr == bus.sr2);
    assign bus.busy_vec   = busy_q;
    assign bus.save_idx   = ptr_q;
    assign bus.save_valid = save_valid;
    assign bus.save_done  = save_done;
    assign bus.ctx_busy   = ctx_busy;
endmodule

// File: tb/tb_reg_file_ctx.sv
// Self-checking bench for reg_file_ctx against an array/bit-vector model.
module tb_reg_file_ctx;
    localparam int DW = 16;
    localparam int NR = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [DW-1:0] mregs [NR];
    logic [NR-1:0] mbusy;

    reg_file_ctx_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) rf ();

    reg_file_ctx #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, applying the register-file rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) mregs[i] = '0;
            mbusy = '0;
        end else begin
            if (rf.ld_reg) begin
                mregs[rf.dr] = rf.data_in;
                mbusy[rf.dr] = 1'b0;
            end
            if (rf.busy_set) mbusy[rf.busy_dr] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [2:0] idx);
        return (rf.ld_reg && rf.dr == idx) ? rf.data_in : mregs[idx];
    endfunction

    task automatic idle_inputs();
        rf.ld_reg = 0; rf.dr = 0; rf.data_in = 0; rf.sr1 = 0; rf.sr2 = 0;
        rf.busy_set = 0; rf.busy_dr = 0; rf.save_req = 0; rf.save_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); tick();
        reset = 0;
        for (int i = 0; i < NR; i++) begin
            rf.ld_reg = 1; rf.dr = 3'(i); rf.data_in = DW'($urandom);
            rf.busy_set = 1; rf.busy_dr = 3'(i);
            tick();
        end
        // Reset wins over a simultaneous write and busy_set.
        reset = 1; rf.ld_reg = 1; rf.dr = 6; rf.data_in = 16'hFFFF;
        rf.busy_set = 1; rf.busy_dr = 6;
        tick();
        reset = 0; idle_inputs();
        #1;
        checks++;
        if (rf.busy_vec !== 8'h00) begin
            failures++; $display("FAIL reset_busy_vec got=%h exp=00", rf.busy_vec);
        end
        checks++;
        if (rf.save_valid !== 0 || rf.save_done !== 0 || rf.ctx_busy !== 0 ||
            rf.save_idx !== 3'd0 || rf.save_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_save got valid=%b done=%b busy=%b idx=%0d data=%h exp=0,0,0,0,0000",
                     rf.save_valid, rf.save_done, rf.ctx_busy, rf.save_idx, rf.save_data);
        end
        for (int i = 0; i < NR; i++) begin
            rf.sr1 = 3'(i); rf.sr2 = 3'(NR - 1 - i);
            #1;
            checks++;
            if (rf.sr1_out !== 16'h0000 || rf.sr2_out !== 16'h0000) begin
                failures++;
                $display("FAIL reset_regs idx=%0d got sr1=%h sr2=%h exp=0000", i, rf.sr1_out, rf.sr2_out);
            end
        end
    endtask

    task automatic test_readback();
        idle_inputs();
        rf.ld_reg = 1; rf.dr = 3; rf.data_in = 16'hBEEF;
        tick();
        rf.ld_reg = 0;
        for (int i = 0; i < NR; i++) begin
            rf.sr1 = 3'(i);
            #1;
            checks++;
            if (rf.sr1_out !== ((i == 3) ? 16'hBEEF : 16'h0000)) begin
                failures++;
                $display("FAIL readback idx=%0d got=%h exp=%h", i, rf.sr1_out, (i == 3) ? 16'hBEEF : 16'h0000);
            end
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        rf.ld_reg = 1; rf.dr = 5; rf.data_in = 16'h1234; rf.sr1 = 5; rf.sr2 = 5;
        #1;
        checks++;
        if (rf.sr1_out !== 16'h1234 || rf.sr2_out !== 16'h1234) begin
            failures++; $display("FAIL bypass got sr1=%h sr2=%h exp=1234", rf.sr1_out, rf.sr2_out);
        end
        tick();
        rf.ld_reg = 0; rf.data_in = 16'h0;
        #1;
        checks++;
        if (rf.sr1_out !== 16'h1234) begin
            failures++; $display("FAIL bypass_stored got=%h exp=1234", rf.sr1_out);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rf.busy_set = 1; rf.busy_dr = 2;
        tick();
        rf.busy_set = 0; rf.sr1 = 2;
        #1;
        checks++;
        if (rf.busy_vec !== 8'h04 || rf.sr1_busy !== 1'b1) begin
            failures++; $display("FAIL sb_set got vec=%h sr1_busy=%b exp=04,1", rf.busy_vec, rf.sr1_busy);
        end
        rf.ld_reg = 1; rf.dr = 2; rf.data_in = 16'h5A5A;
        #1;
        checks++;
        if (rf.sr1_busy !== 1'b0 || rf.sr1_out !== 16'h5A5A) begin
            failures++; $display("FAIL sb_writeback got busy=%b data=%h exp=0,5a5a", rf.sr1_busy, rf.sr1_out);
        end
        tick();
        rf.ld_reg = 0;
        #1;
        checks++;
        if (rf.busy_vec !== 8'h00) begin
            failures++; $display("FAIL sb_clear got=%h exp=00", rf.busy_vec);
        end
        rf.ld_reg = 1; rf.dr = 2; rf.data_in = 16'h0F0F; rf.busy_set = 1; rf.busy_dr = 2;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rf.busy_vec !== 8'h04) begin
            failures++; $display("FAIL sb_set_wins got=%h exp=04", rf.busy_vec);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            rf.ld_reg   = 1'($urandom_range(0, 1));
            rf.dr       = 3'($urandom);
            rf.data_in  = DW'($urandom);
            rf.sr1      = 3'($urandom);
            rf.sr2      = 3'($urandom);
            rf.busy_set = ($urandom_range(0, 3) == 0);
            rf.busy_dr  = 3'($urandom);
            #1;
            checks++;
            if (rf.sr1_out !== exp_rd(rf.sr1) || rf.sr2_out !== exp_rd(rf.sr2)) begin
                failures++;
                $display("FAIL rand_read n=%0d got=%h,%h exp=%h,%h", n, rf.sr1_out, rf.sr2_out,
                         exp_rd(rf.sr1), exp_rd(rf.sr2));
            end
            checks++;
            if (rf.sr1_busy !== (mbusy[rf.sr1] && !(rf.ld_reg && rf.dr == rf.sr1)) ||
                rf.sr2_busy !== (mbusy[rf.sr2] && !(rf.ld_reg && rf.dr == rf.sr2))) begin
                failures++;
                $display("FAIL rand_busy n=%0d got=%b,%b vec_model=%h", n, rf.sr1_busy, rf.sr2_busy, mbusy);
            end
            tick();
            checks++;
            if (rf.busy_vec !== mbusy) begin
                failures++; $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, rf.busy_vec, mbusy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_save_backpressure();
        int            exp_idx;
        int            save_cyc;
        bit            done_seen;
        logic [DW-1:0] exp_data;
        idle_inputs();
        for (int i = 0; i < NR; i++) begin
            rf.ld_reg = 1; rf.dr = 3'(i); rf.data_in = 16'h1000 + DW'(i);
            tick();
        end
        idle_inputs();
        rf.save_req = 1;
        tick();
        rf.save_req = 0;
        exp_idx = 0; save_cyc = 0; done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            rf.save_ready = (c % 2 == 0);
            rf.save_req   = (c == 3);
            #1;
            if (rf.save_valid) begin
                save_cyc++;
                exp_data = 16'h1000 + DW'(exp_idx);
                checks++;
                if (exp_idx >= NR || rf.save_idx !== 3'(exp_idx) || rf.save_data !== exp_data ||
                    rf.ctx_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_beat c=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             c, rf.save_idx, rf.save_data, exp_idx, exp_data);
                end
                if (rf.save_ready) exp_idx++;
            end
            if (rf.save_done) begin
                done_seen = 1;
                checks++;
                if (exp_idx != NR || save_cyc != 15) begin
                    failures++;
                    $display("FAIL bp_done got beats=%0d save_cycles=%0d exp=8,15", exp_idx, save_cyc);
                end
            end
            tick();
        end
        rf.save_req = 0; rf.save_ready = 1;
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL bp_timeout got done=0 exp=1");
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (rf.ctx_busy !== 1'b0 || rf.save_valid !== 1'b0 || rf.save_done !== 1'b0) begin
                failures++;
                $display("FAIL bp_idle k=%0d got busy=%b valid=%b done=%b exp=0", k,
                         rf.ctx_busy, rf.save_valid, rf.save_done);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_during_save();
        int exp_idx;
        int stall;
        bit done_seen;
        idle_inputs();
        rf.save_req = 1;
        tick();
        rf.save_req = 0;
        exp_idx = 0; stall = 0; done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            rf.ld_reg = 0;
            if (exp_idx == 4 && stall < 2) begin
                rf.save_ready = 0;
                if (stall == 0) begin
                    rf.ld_reg = 1; rf.dr = 4; rf.data_in = 16'hAAAA;
                end
                stall++;
            end else begin
                rf.save_ready = 1;
            end
            #1;
            if (rf.save_valid) begin
                checks++;
                if (exp_idx >= NR || rf.save_idx !== 3'(exp_idx) || rf.save_data !== exp_rd(3'(exp_idx))) begin
                    failures++;
                    $display("FAIL wds_beat c=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             c, rf.save_idx, rf.save_data, exp_idx, exp_rd(3'(exp_idx)));
                end
                if (rf.save_ready) begin
                    if (exp_idx == 4) begin
                        checks++;
                        if (rf.save_data !== 16'hAAAA) begin
                            failures++; $display("FAIL wds_beat4 got=%h exp=aaaa", rf.save_data);
                        end
                    end
                    exp_idx++;
                end
            end
            if (rf.save_done) done_seen = 1;
            tick();
        end
        checks++;
        if (!done_seen || exp_idx != NR) begin
            failures++; $display("FAIL wds_done got done=%b beats=%0d exp=1,8", done_seen, exp_idx);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_save();
        int exp_idx;
        int done_c;
        bit bad_done;
        idle_inputs();
        rf.save_req = 1;
        tick();
        rf.save_req = 0; rf.save_ready = 1;
        for (int k = 0; k < 3; k++) tick();
        #1;
        checks++;
        if (rf.save_valid !== 1'b1 || rf.save_idx !== 3'd3) begin
            failures++; $display("FAIL rms_pre got valid=%b idx=%0d exp=1,3", rf.save_valid, rf.save_idx);
        end
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if (rf.save_valid !== 1'b0 || rf.ctx_busy !== 1'b0) begin
            failures++; $display("FAIL rms_idle got valid=%b busy=%b exp=0,0", rf.save_valid, rf.ctx_busy);
        end
        bad_done = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rf.save_done !== 1'b0 || rf.save_valid !== 1'b0) bad_done = 1;
            tick();
        end
        checks++;
        if (bad_done) begin
            failures++; $display("FAIL rms_no_done got spurious done/valid exp=none");
        end
        rf.save_req = 1;
        tick();
        rf.save_req = 0;
        exp_idx = 0; done_c = -1;
        for (int c = 0; c < 30 && done_c < 0; c++) begin
            #1;
            if (rf.save_valid) begin
                checks++;
                if (exp_idx >= NR || rf.save_idx !== 3'(exp_idx) || rf.save_data !== mregs[3'(exp_idx)]) begin
                    failures++;
                    $display("FAIL rms_restart c=%0d got idx=%0d data=%h exp idx=%0d", c,
                             rf.save_idx, rf.save_data, exp_idx);
                end
                exp_idx++;
            end
            if (rf.save_done) done_c = c;
            tick();
        end
        checks++;
        if (done_c != NR || exp_idx != NR) begin
            failures++; $display("FAIL rms_timing got done_cycle=%0d beats=%0d exp=8,8", done_c, exp_idx);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        idle_inputs();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mbusy = '0;
        @(negedge clk);
        test_reset();
        test_readback();
        test_bypass();
        test_scoreboard();
        test_random();
        test_save_backpressure();
        test_write_during_save();
        test_reset_mid_save();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_ctx.md
# reg_file_ctx

Parametrised general-purpose register file for the SLC-3 datapath. Generalises the fixed 8×16 register file in data width and register count. It adds write-through read bypass and a per-register busy scoreboard for outstanding MMIO/memory loads. It also adds a context-save engine that streams every register out over a valid/ready handshake, for trap and interrupt entry. It sits between the DR/SR1 muxes and the ALU/bus, and the context stream feeds the MMIO/memory write path.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each register
- NUM_REGS, 8, register count; must be a power of two and at least 2
- AW, $clog2(NUM_REGS), index width; derived, not overridden

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ld_reg  in  1  write enable for register dr
- dr  in  AW  destination register index
- data_in  in  DATA_WIDTH  write data from the bus
- sr1  in  AW  read port 1 index, driven by the external SR1 mux
- sr2  in  AW  read port 2 index
- sr1_out  out  DATA_WIDTH  read port 1 data
- sr2_out  out  DATA_WIDTH  read port 2 data
- busy_set  in  1  marks register busy_dr as pending, for a load that has been issued but not yet written back
- busy_dr  in  AW  index to mark busy
- busy_vec  out  NUM_REGS  per-register pending bits
- sr1_busy  out  1  sr1 operand not yet available
- sr2_busy  out  1  sr2 operand not yet available
- save_req  in  1  request a context save; sampled in IDLE only
- save_valid  out  1  save_data and save_idx are valid
- save_ready  in  1  consumer accepts the current beat
- save_idx  out  AW  index of the register being streamed
- save_data  out  DATA_WIDTH  value of the register being streamed
- save_done  out  1  one-cycle pulse after the last beat
- ctx_busy  out  1  save engine active (SAVE or DONE)

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops. On ld_reg, reg[dr] <= data_in at the next edge.
- Reads are combinational.
  - srX_out = data_in when ld_reg && dr == srX (write-through bypass).
  - Otherwise srX_out = reg[srX].
- Scoreboard:
  - busy_set sets busy_vec[busy_dr].
  - ld_reg clears busy_vec[dr].
  - When both target the same index in the same cycle, set wins and the bit stays 1.
  - Different indices update independently.
- Busy flags: srX_busy = busy_vec[srX] && !(ld_reg && dr == srX). A writeback in the same cycle satisfies the operand through the bypass.
- The save FSM has three states: IDLE, SAVE, DONE.
  - IDLE: when save_req = 1, go to SAVE with ptr <= 0.
  - SAVE: save_valid = 1, save_idx = ptr, and save_data = reg[ptr] with the same bypass as the read ports.
    - When save_valid && save_ready: if ptr == NUM_REGS-1, go to DONE; otherwise ptr <= ptr + 1.
    - Without save_ready, hold ptr, idx and state.
  - DONE: save_done = 1 for one cycle, then go to IDLE.
- ctx_busy = 1 in SAVE and in DONE.
- save_req is ignored outside IDLE and is not queued.
- ld_reg and busy_set keep working normally during a save. A beat always carries the register's value as of the cycle it is accepted.
- reset has priority over all other inputs in the same cycle.

## Timing
- Reset values:
  - All registers are 0.
  - busy_vec = 0 and ptr = 0.
  - The FSM is in IDLE.
  - save_valid, save_done and ctx_busy are 0.
  - save_idx = 0 and save_data = reg[0], which is 0.
  - sr1_out and sr2_out show registers, which are 0.
- Write latency: 1 edge into storage; 0 cycles to the read ports through the bypass.
- busy_vec updates 1 edge after busy_set or ld_reg.
- Save timing with save_ready held high:
  - save_req is sampled at edge E.
  - Beats are accepted in cycles E+1 … E+NUM_REGS.
  - save_done is high in cycle E+NUM_REGS+1.
  - The FSM is back in IDLE at cycle E+NUM_REGS+2.
- Each low cycle of save_ready stretches the sequence by exactly one cycle.
- Reset in SAVE or DONE: return to IDLE next edge, with no save_done pulse.

## Test plan
- Reset/readback: assert reset for 1 cycle, write r3 = 0xBEEF, then read sr1 = 3 next cycle -> sr1_out = 0xBEEF. All other registers read 0.
- Bypass: ld_reg = 1, dr = 5, data_in = 0x1234, sr1 = sr2 = 5 in the same cycle -> both outputs 0x1234 combinationally, and reg[5] = 0x1234 after the edge.
- Scoreboard:
  - busy_set on r2 -> busy_vec = 0x04 and sr1_busy = 1 with sr1 = 2.
  - ld_reg to r2 -> sr1_busy = 0 in the same cycle, and busy_vec = 0x00 next edge.
  - busy_set and ld_reg both on r2 in one cycle -> busy_vec[2] stays 1.
- Save with backpressure:
  - Setup: registers hold r_i = 0x1000 + i; pulse save_req; toggle save_ready 1,0,1,0…
  - Beats arrive as idx 0..7 with data 0x1000..0x1007, in order with no duplicates.
  - save_done pulses once, after 15 cycles in SAVE.
  - A save_req during SAVE is ignored.
- Write during save: with ptr = 4 stalled by save_ready = 0, write r4 = 0xAAAA, then raise save_ready -> the accepted beat 4 carries 0xAAAA.
- Reset mid-save: reset at beat 3 -> FSM in IDLE and save_valid = 0 next cycle, save_done is never asserted, and a new save_req restarts at idx 0.
